// File: rtl/pn_pkg.sv
// Shared types and constants for the Polish Notation token feeder.
package pn_pkg;

  localparam int PN_MAX_TOK = 12;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_MUL = 3'd2;
  localparam logic [2:0] OP_ABS = 3'd3;

  typedef enum logic [1:0] {
    FILL     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_RES = 2'd2,
    GAP      = 2'd3
  } pn_state_e;

  typedef struct packed {
    logic       op;
    logic [2:0] val;
  } pn_tok_t;

  // Operator codes above OP_ABS are not understood by the evaluator.
  function automatic logic pn_bad_op(input pn_tok_t t);
    return t.op && (t.val > OP_ABS);
  endfunction

endpackage

// File: rtl/pn_tok_buf.sv
// Frame token store: one write port used while filling, one read port used while issuing.
module pn_tok_buf
  import pn_pkg::*;
#(
  parameter int DEPTH = PN_MAX_TOK,
  parameter int IW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [IW-1:0] wr_idx,
  input  pn_tok_t       wr_tok,
  input  logic [IW-1:0] rd_idx,
  output pn_tok_t       rd_tok
);

  pn_tok_t [DEPTH-1:0] mem;

  // Clear wins over a same-cycle write so a rejected frame leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem <= '0;
    end else if (clr) begin
      mem <= '0;
    end else if (we) begin
      for (int i = 0; i < DEPTH; i++)
        if (wr_idx == IW'(i)) mem[i] <= wr_tok;
    end
  end

  always_comb begin
    rd_tok = '0;
    for (int i = 0; i < DEPTH; i++)
      if (rd_idx == IW'(i)) rd_tok = mem[i];
  end

endmodule

// File: rtl/pn_token_feeder.sv
// Buffers one host token frame, replays it to the PN evaluator as an unbroken burst,
// then waits for the evaluator's result burst (or a timeout) before taking the next frame.
module pn_token_feeder
  import pn_pkg::*;
#(
  parameter int MAX_TOK = PN_MAX_TOK,
  parameter int MIN_TOK = 3,
  parameter int GAP_CYC = 2,
  parameter int TIMEOUT = 64
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tok_valid,
  output logic       tok_ready,
  input  logic       tok_op,
  input  logic [2:0] tok_val,
  input  logic       tok_last,
  input  logic [1:0] frame_mode,
  output logic       pn_in_valid,
  output logic [1:0] pn_mode,
  output logic       pn_operator,
  output logic [2:0] pn_in,
  input  logic       pn_out_valid,
  output logic       busy,
  output logic       frame_done,
  output logic       err_len,
  output logic       err_op,
  output logic       err_timeout
);

  localparam int CW = $clog2(MAX_TOK + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYC + 1);
  localparam logic [CW-1:0] MAX_C = CW'(MAX_TOK);
  localparam logic [CW-1:0] MIN_C = CW'(MIN_TOK);
  localparam logic [TW-1:0] TMO_C = TW'(TIMEOUT);
  localparam logic [GW-1:0] GAP_C = GW'(GAP_CYC);

  pn_state_e     state, state_d;
  logic [CW-1:0] cnt, cnt_d, idx, idx_d;
  logic [1:0]    mode_q, mode_d;
  logic          ovf, ovf_d, bad, bad_d, ov_q, ov_d;
  logic [TW-1:0] tmo, tmo_d;
  logic [GW-1:0] gap_cnt, gap_d;

  logic          in_valid_d, operator_d, done_d, elen_d, eop_d, etmo_d;
  logic [1:0]    pn_mode_d;
  logic [2:0]    pn_in_d;

  logic          buf_we, buf_clr, tok_acc;
  pn_tok_t       wr_tok, rd_tok;

  assign tok_ready = (state == FILL);
  assign busy      = (state != FILL);
  assign tok_acc   = tok_valid && tok_ready;
  assign wr_tok    = '{op: tok_op, val: tok_val};

  pn_tok_buf #(.DEPTH(MAX_TOK), .IW(CW)) u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (buf_clr),
    .we     (buf_we),
    .wr_idx (cnt),
    .wr_tok (wr_tok),
    .rd_idx (idx),
    .rd_tok (rd_tok)
  );

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    idx_d      = idx;
    mode_d     = mode_q;
    ovf_d      = ovf;
    bad_d      = bad;
    tmo_d      = tmo;
    gap_d      = gap_cnt;
    ov_d       = 1'b0;
    buf_we     = 1'b0;
    buf_clr    = 1'b0;
    in_valid_d = 1'b0;
    pn_mode_d  = '0;
    operator_d = 1'b0;
    pn_in_d    = '0;
    done_d     = 1'b0;
    elen_d     = 1'b0;
    eop_d      = 1'b0;
    etmo_d     = 1'b0;

    case (state)
      FILL: begin
        if (tok_acc) begin
          if (cnt == '0 && !ovf) mode_d = frame_mode;
          if (cnt < MAX_C) begin
            buf_we = 1'b1;
            cnt_d  = cnt + CW'(1);
          end else begin
            ovf_d = 1'b1;
          end
          if (pn_bad_op(wr_tok)) bad_d = 1'b1;
          if (tok_last) begin
            // Length errors take precedence over a bad operator.
            if (ovf_d || cnt_d < MIN_C) elen_d = 1'b1;
            else if (bad_d)             eop_d  = 1'b1;
            if (elen_d || eop_d) begin
              buf_clr = 1'b1;
              cnt_d   = '0;
              ovf_d   = 1'b0;
              bad_d   = 1'b0;
            end else begin
              state_d = ISSUE;
              idx_d   = '0;
            end
          end
        end
      end

      ISSUE: begin
        in_valid_d = 1'b1;
        pn_mode_d  = mode_q;
        operator_d = rd_tok.op;
        pn_in_d    = rd_tok.val;
        idx_d      = idx + CW'(1);
        if (idx_d == cnt) begin
          state_d = WAIT_RES;
          tmo_d   = '0;
        end
      end

      WAIT_RES: begin
        ov_d = pn_out_valid;
        if (pn_out_valid) begin
          tmo_d = '0;
        end else begin
          if (tmo != TMO_C) tmo_d = tmo + TW'(1);
          // ov_q high with pn_out_valid low is the falling edge of the result burst.
          if (ov_q) begin
            done_d  = 1'b1;
            state_d = GAP;
            gap_d   = '0;
          end else if (tmo_d == TMO_C) begin
            etmo_d  = 1'b1;
            state_d = GAP;
            gap_d   = '0;
          end
        end
      end

      GAP: begin
        gap_d = gap_cnt + GW'(1);
        if (gap_d == GAP_C) begin
          state_d = FILL;
          cnt_d   = '0;
          idx_d   = '0;
          ovf_d   = 1'b0;
          bad_d   = 1'b0;
          buf_clr = 1'b1;
        end
      end

      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      cnt         <= '0;
      idx         <= '0;
      mode_q      <= '0;
      ovf         <= 1'b0;
      bad         <= 1'b0;
      tmo         <= '0;
      gap_cnt     <= '0;
      ov_q        <= 1'b0;
      pn_in_valid <= 1'b0;
      pn_mode     <= '0;
      pn_operator <= 1'b0;
      pn_in       <= '0;
      frame_done  <= 1'b0;
      err_len     <= 1'b0;
      err_op      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      idx         <= idx_d;
      mode_q      <= mode_d;
      ovf         <= ovf_d;
      bad         <= bad_d;
      tmo         <= tmo_d;
      gap_cnt     <= gap_d;
      ov_q        <= ov_d;
      pn_in_valid <= in_valid_d;
      pn_mode     <= pn_mode_d;
      pn_operator <= operator_d;
      pn_in       <= pn_in_d;
      frame_done  <= done_d;
      err_len     <= elen_d;
      err_op      <= eop_d;
      err_timeout <= etmo_d;
    end
  end

endmodule

// File: tb/tb_pn_token_feeder.sv
// Scoreboard bench for pn_token_feeder: burst contents checked by a negedge monitor,
// handshake timing and status pulses checked inline by each scenario task.
module tb_pn_token_feeder;
  import pn_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tok_valid = 1'b0, tok_op = 1'b0, tok_last = 1'b0;
  logic [2:0] tok_val = '0;
  logic [1:0] frame_mode = '0;
  logic       pn_out_valid = 1'b0;
  logic       tok_ready, pn_in_valid, pn_operator, busy;
  logic       frame_done, err_len, err_op, err_timeout;
  logic [1:0] pn_mode;
  logic [2:0] pn_in;

  always #5 clk = ~clk;

  pn_token_feeder dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tok_valid    (tok_valid),
    .tok_ready    (tok_ready),
    .tok_op       (tok_op),
    .tok_val      (tok_val),
    .tok_last     (tok_last),
    .frame_mode   (frame_mode),
    .pn_in_valid  (pn_in_valid),
    .pn_mode      (pn_mode),
    .pn_operator  (pn_operator),
    .pn_in        (pn_in),
    .pn_out_valid (pn_out_valid),
    .busy         (busy),
    .frame_done   (frame_done),
    .err_len      (err_len),
    .err_op       (err_op),
    .err_timeout  (err_timeout)
  );

  typedef struct packed {
    logic       op;
    logic [2:0] val;
    logic [1:0] mode;
  } exp_t;

  exp_t       sb[$];
  logic       fo[$];
  logic [2:0] fv[$];
  int n_chk = 0, n_pass = 0, n_vld = 0;
  int c_done = 0, c_elen = 0, c_eop = 0, c_etmo = 0;
  logic prev_vld = 1'b0;

  // Burst monitor: every pn_in_valid cycle must match the head of the scoreboard,
  // and a burst may only end once all expected tokens have been seen.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_vld = 1'b0;
    end else begin
      if (pn_in_valid) begin
        exp_t e;
        n_vld++;
        n_chk++;
        if (sb.size() == 0) begin
          $display("FAIL burst_extra: got op=%0b val=%0d mode=%0d, expected no burst", pn_operator, pn_in, pn_mode);
        end else begin
          e = sb.pop_front();
          if ({pn_operator, pn_in, pn_mode} !== e)
            $display("FAIL burst_tok: got op=%0b val=%0d mode=%0d, expected op=%0b val=%0d mode=%0d",
                     pn_operator, pn_in, pn_mode, e.op, e.val, e.mode);
          else n_pass++;
        end
      end else if (prev_vld) begin
        n_chk++;
        if (sb.size() != 0) $display("FAIL burst_gap: burst ended with %0d tokens outstanding, expected 0", sb.size());
        else n_pass++;
      end
      if (frame_done)  c_done++;
      if (err_len)     c_elen++;
      if (err_op)      c_eop++;
      if (err_timeout) c_etmo++;
      prev_vld = pn_in_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add_tok(input logic op, input logic [2:0] v);
    fo.push_back(op);
    fv.push_back(v);
  endtask

  // Drives the staged frame; pushes the expected burst only when the frame is legal.
  // frame_mode is inverted after the first token to show it is latched only once.
  task automatic send_frame(input logic [1:0] mode);
    int  n = fo.size();
    bit  legal;
    int  w;
    legal = (n >= 3 && n <= PN_MAX_TOK);
    for (int i = 0; i < n; i++) if (fo[i] && fv[i] > 3'd3) legal = 0;
    if (legal) for (int i = 0; i < n; i++) sb.push_back('{op: fo[i], val: fv[i], mode: mode});
    for (int i = 0; i < n; i++) begin
      tok_valid  = 1'b1;
      tok_op     = fo[i];
      tok_val    = fv[i];
      tok_last   = (i == n - 1);
      frame_mode = (i == 0) ? mode : ~mode;
      w = 0;
      while (!tok_ready && w < 300) begin tick(); w++; end
      if (w >= 300) begin
        n_chk++;
        $display("FAIL tok_ready_wait: tok_ready stayed 0 for %0d cycles, expected 1", w);
      end
      tick();
    end
    tok_valid = 1'b0;
    tok_last  = 1'b0;
    fo.delete();
    fv.delete();
  endtask

  task automatic wait_burst_done();
    int w = 0;
    while (!pn_in_valid && w < 50) begin tick(); w++; end
    if (w >= 50) begin
      n_chk++;
      $display("FAIL burst_start: pn_in_valid=0 after %0d cycles, expected 1", w);
    end
    w = 0;
    while (pn_in_valid && w < 50) begin tick(); w++; end
    if (w >= 50) begin
      n_chk++;
      $display("FAIL burst_end: pn_in_valid=1 after %0d cycles, expected 0", w);
    end
  endtask

  task automatic send_result(input int len);
    pn_out_valid = 1'b1;
    repeat (len) tick();
    pn_out_valid = 1'b0;
  endtask

  task automatic test_reset();
    #12;
    n_chk++;
    if ({pn_in_valid, pn_mode, pn_operator, pn_in, busy, frame_done, err_len, err_op, err_timeout} !== '0)
      $display("FAIL reset_outs: got %b, expected all zero", {pn_in_valid, pn_mode, pn_operator, pn_in, busy, frame_done, err_len, err_op, err_timeout});
    else n_pass++;
    @(posedge clk); #1 rst_n = 1'b1;
    tick();
    n_chk++;
    if (tok_ready !== 1'b1 || busy !== 1'b0 || pn_in_valid !== 1'b0)
      $display("FAIL reset_release: tok_ready=%0b busy=%0b pn_in_valid=%0b, expected 1 0 0", tok_ready, busy, pn_in_valid);
    else n_pass++;
  endtask

  task automatic test_basic();
    int d0 = c_done;
    add_tok(1'b0, 3'd3); add_tok(1'b0, 3'd4); add_tok(1'b1, OP_ADD);
    send_frame(2'd3);
    n_chk++;
    if (pn_in_valid !== 1'b0) $display("FAIL basic_latency_lo: pn_in_valid=%0b, expected 0", pn_in_valid);
    else n_pass++;
    tick();
    n_chk++;
    if (pn_in_valid !== 1'b1 || tok_ready !== 1'b0 || busy !== 1'b1)
      $display("FAIL basic_latency_hi: valid=%0b ready=%0b busy=%0b, expected 1 0 1", pn_in_valid, tok_ready, busy);
    else n_pass++;
    wait_burst_done();
    send_result(1);
    tick();
    n_chk++;
    if (frame_done !== 1'b1 || tok_ready !== 1'b0)
      $display("FAIL basic_done: frame_done=%0b tok_ready=%0b, expected 1 0", frame_done, tok_ready);
    else n_pass++;
    tick();
    n_chk++;
    if (frame_done !== 1'b0 || tok_ready !== 1'b0)
      $display("FAIL basic_gap: frame_done=%0b tok_ready=%0b, expected 0 0", frame_done, tok_ready);
    else n_pass++;
    tick();
    n_chk++;
    if (tok_ready !== 1'b1 || busy !== 1'b0 || c_done - d0 !== 1)
      $display("FAIL basic_refill: tok_ready=%0b busy=%0b done_pulses=%0d, expected 1 0 1", tok_ready, busy, c_done - d0);
    else n_pass++;
  endtask

  task automatic test_full_frame();
    int d0 = c_done, v0 = n_vld;
    add_tok(1'b0, 3'd1); add_tok(1'b0, 3'd2); add_tok(1'b1, OP_ADD);
    add_tok(1'b0, 3'd3); add_tok(1'b0, 3'd4); add_tok(1'b1, OP_SUB);
    add_tok(1'b0, 3'd5); add_tok(1'b0, 3'd6); add_tok(1'b1, OP_MUL);
    add_tok(1'b0, 3'd7); add_tok(1'b0, 3'd0); add_tok(1'b1, OP_ABS);
    send_frame(2'd1);
    // Host keeps offering a token while the feeder is busy; it must be ignored.
    tok_valid = 1'b1; tok_last = 1'b1; tok_op = 1'b1; tok_val = 3'd7;
    wait_burst_done();
    tok_valid = 1'b0; tok_last = 1'b0;
    n_chk++;
    if (n_vld - v0 !== 12) $display("FAIL full_len: burst cycles=%0d, expected 12", n_vld - v0);
    else n_pass++;
    send_result(4);
    repeat (4) tick();
    n_chk++;
    if (c_done - d0 !== 1 || tok_ready !== 1'b1 || c_eop != 0 || c_elen != 0)
      $display("FAIL full_done: done_pulses=%0d tok_ready=%0b err_op=%0d err_len=%0d, expected 1 1 0 0",
               c_done - d0, tok_ready, c_eop, c_elen);
    else n_pass++;
  endtask

  task automatic test_len_err();
    int e0 = c_elen, v0 = n_vld, o0 = c_eop;
    add_tok(1'b0, 3'd1); add_tok(1'b0, 3'd2);
    send_frame(2'd0);
    n_chk++;
    if (err_len !== 1'b1 || tok_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL len_short: err_len=%0b tok_ready=%0b busy=%0b, expected 1 1 0", err_len, tok_ready, busy);
    else n_pass++;
    tick();
    n_chk++;
    if (err_len !== 1'b0) $display("FAIL len_pulse: err_len=%0b, expected 0", err_len);
    else n_pass++;
    for (int i = 0; i < 13; i++)
      if (i % 3 == 2) add_tok(1'b1, OP_MUL);
      else add_tok(1'b0, 3'(i % 8));
    send_frame(2'd2);
    n_chk++;
    if (err_len !== 1'b1) $display("FAIL len_long: err_len=%0b, expected 1", err_len);
    else n_pass++;
    add_tok(1'b0, 3'd1); add_tok(1'b1, 3'd7);
    send_frame(2'd1);
    n_chk++;
    if (err_len !== 1'b1 || err_op !== 1'b0)
      $display("FAIL len_over_op: err_len=%0b err_op=%0b, expected 1 0", err_len, err_op);
    else n_pass++;
    repeat (3) tick();
    n_chk++;
    if (n_vld - v0 !== 0 || c_elen - e0 !== 3 || c_eop - o0 !== 0)
      $display("FAIL len_summary: burst=%0d err_len=%0d err_op=%0d, expected 0 3 0", n_vld - v0, c_elen - e0, c_eop - o0);
    else n_pass++;
  endtask

  task automatic test_op_err();
    int o0 = c_eop, d0 = c_done, v0 = n_vld;
    add_tok(1'b0, 3'd1); add_tok(1'b0, 3'd2); add_tok(1'b1, 3'd5);
    send_frame(2'd2);
    n_chk++;
    if (err_op !== 1'b1 || err_len !== 1'b0 || tok_ready !== 1'b1)
      $display("FAIL op_err: err_op=%0b err_len=%0b tok_ready=%0b, expected 1 0 1", err_op, err_len, tok_ready);
    else n_pass++;
    add_tok(1'b0, 3'd6); add_tok(1'b0, 3'd1); add_tok(1'b1, OP_SUB);
    send_frame(2'd2);
    wait_burst_done();
    send_result(2);
    repeat (4) tick();
    n_chk++;
    if (c_eop - o0 !== 1 || c_done - d0 !== 1 || n_vld - v0 !== 3 || tok_ready !== 1'b1)
      $display("FAIL op_recover: err_op=%0d done=%0d burst=%0d ready=%0b, expected 1 1 3 1",
               c_eop - o0, c_done - d0, n_vld - v0, tok_ready);
    else n_pass++;
  endtask

  task automatic test_timeout();
    int t0 = c_etmo, d0 = c_done, k = 0;
    add_tok(1'b0, 3'd5); add_tok(1'b0, 3'd2); add_tok(1'b1, OP_MUL);
    send_frame(2'd0);
    tick();
    // Result activity during the burst falls outside WAIT_RES and must not count.
    pn_out_valid = 1'b1;
    tick();
    pn_out_valid = 1'b0;
    wait_burst_done();
    // Observation starts one cycle into WAIT_RES, so the pulse lands TIMEOUT-1 cycles later.
    while (!err_timeout && k < 200) begin tick(); k++; end
    n_chk++;
    if (k !== 63) $display("FAIL tmo_delay: err_timeout after %0d cycles, expected 63", k);
    else n_pass++;
    tick();
    n_chk++;
    if (tok_ready !== 1'b0 || err_timeout !== 1'b0)
      $display("FAIL tmo_gap: tok_ready=%0b err_timeout=%0b, expected 0 0", tok_ready, err_timeout);
    else n_pass++;
    tick();
    n_chk++;
    if (tok_ready !== 1'b1 || c_etmo - t0 !== 1 || c_done - d0 !== 0)
      $display("FAIL tmo_refill: tok_ready=%0b timeouts=%0d done=%0d, expected 1 1 0", tok_ready, c_etmo - t0, c_done - d0);
    else n_pass++;
  endtask

  task automatic test_reset_mid_burst();
    int d0, e0, o0, t0;
    add_tok(1'b0, 3'd1); add_tok(1'b0, 3'd2); add_tok(1'b1, OP_ADD);
    add_tok(1'b0, 3'd3); add_tok(1'b1, OP_MUL);
    send_frame(2'd2);
    repeat (3) tick();
    rst_n = 1'b0;
    sb.delete();
    #1;
    n_chk++;
    if (pn_in_valid !== 1'b0 || pn_mode !== 2'd0 || tok_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL rst_mid: valid=%0b mode=%0d ready=%0b busy=%0b, expected 0 0 1 0", pn_in_valid, pn_mode, tok_ready, busy);
    else n_pass++;
    d0 = c_done; e0 = c_elen; o0 = c_eop; t0 = c_etmo;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    n_chk++;
    if (tok_ready !== 1'b1 || c_done != d0 || c_elen != e0 || c_eop != o0 || c_etmo != t0)
      $display("FAIL rst_quiet: tok_ready=%0b pulses=%0d, expected 1 0", tok_ready,
               (c_done - d0) + (c_elen - e0) + (c_eop - o0) + (c_etmo - t0));
    else n_pass++;
    add_tok(1'b0, 3'd7); add_tok(1'b0, 3'd7); add_tok(1'b1, OP_ABS);
    send_frame(2'd1);
    wait_burst_done();
    send_result(1);
    repeat (4) tick();
    n_chk++;
    if (c_done - d0 !== 1 || tok_ready !== 1'b1)
      $display("FAIL rst_next: done=%0d tok_ready=%0b, expected 1 1", c_done - d0, tok_ready);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_frame();
    test_len_err();
    test_op_err();
    test_timeout();
    test_reset_mid_burst();
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
